// File: rtl/reorder_buffer_if.sv
// Dispatch / writeback / lookup / commit bundle for the reorder buffer.
// The master side is the core pipeline, and the slave side is the buffer itself.
interface reorder_buffer_if #(
    parameter int TAG_W  = 3,
    parameter int REG_W  = 5,
    parameter int DATA_W = 64
);
    logic              flush;
    logic              alloc_valid;
    logic              alloc_ready;
    logic              alloc_wr_en;
    logic [REG_W-1:0]  alloc_dest;
    logic [TAG_W-1:0]  alloc_tag;
    logic              wb_valid;
    logic [TAG_W-1:0]  wb_tag;
    logic [DATA_W-1:0] wb_data;
    logic [TAG_W-1:0]  rd_tag;
    logic              rd_done;
    logic [DATA_W-1:0] rd_data;
    logic              commit_valid;
    logic              commit_wr_en;
    logic [REG_W-1:0]  commit_dest;
    logic [DATA_W-1:0] commit_data;
    logic [TAG_W-1:0]  commit_tag;
    logic [TAG_W:0]    count;

    modport master (
        output flush, alloc_valid, alloc_wr_en, alloc_dest,
               wb_valid, wb_tag, wb_data, rd_tag,
        input  alloc_ready, alloc_tag, rd_done, rd_data,
               commit_valid, commit_wr_en, commit_dest, commit_data, commit_tag, count
    );

    modport slave (
        input  flush, alloc_valid, alloc_wr_en, alloc_dest,
               wb_valid, wb_tag, wb_data, rd_tag,
        output alloc_ready, alloc_tag, rd_done, rd_data,
               commit_valid, commit_wr_en, commit_dest, commit_data, commit_tag, count
    );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: entries are allocated in program order, results are written back by tag,
// and the head entry retires once its result is present.
module reorder_buffer #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 3,
    parameter int REG_W  = 5,
    parameter int DATA_W = 64
) (
    input  logic           clk,
    input  logic           reset,
    reorder_buffer_if.slave bus
);
    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  done_q;
    logic              wr_en_q [DEPTH];
    logic [REG_W-1:0]  dest_q  [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [TAG_W-1:0]  head_q;
    logic [TAG_W-1:0]  tail_q;
    logic [TAG_W:0]    count_q;

    logic alloc_fire;
    logic wb_fire;
    logic commit_fire;
    logic rd_valid;
    logic rd_stored;
    logic rd_bypass;

    assign bus.alloc_ready = (count_q != FULL_COUNT);
    assign bus.alloc_tag   = tail_q;
    assign bus.count       = count_q;

    assign alloc_fire  = bus.alloc_valid && bus.alloc_ready && !bus.flush;
    assign wb_fire     = bus.wb_valid && valid_q[bus.wb_tag] && !bus.flush;
    assign commit_fire = valid_q[head_q] && done_q[head_q] && !bus.flush;

    assign bus.commit_valid = commit_fire;
    assign bus.commit_wr_en = commit_fire && wr_en_q[head_q];
    assign bus.commit_dest  = commit_fire ? dest_q[head_q] : '0;
    assign bus.commit_data  = commit_fire ? data_q[head_q] : '0;
    assign bus.commit_tag   = commit_fire ? head_q : '0;

    // A result arriving this cycle is forwarded to the operand lookup ahead of the stored copy.
    assign rd_valid    = valid_q[bus.rd_tag];
    assign rd_stored   = rd_valid && done_q[bus.rd_tag];
    assign rd_bypass   = bus.wb_valid && (bus.wb_tag == bus.rd_tag) && rd_valid;
    assign bus.rd_done = rd_bypass || rd_stored;
    assign bus.rd_data = rd_bypass ? bus.wb_data : (rd_stored ? data_q[bus.rd_tag] : '0);

    // The retire clear comes after the writeback set, so a late writeback can never revive a retiring head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (wb_fire) begin
                done_q[bus.wb_tag] <= 1'b1;
            end
            if (commit_fire) begin
                valid_q[head_q] <= 1'b0;
                done_q[head_q]  <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (alloc_fire) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
                tail_q          <= tail_q + 1'b1;
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload fields are qualified by the valid/done bits, so they carry no reset.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            wr_en_q[tail_q] <= bus.alloc_wr_en;
            dest_q[tail_q]  <= bus.alloc_dest;
        end
        if (wb_fire) begin
            data_q[bus.wb_tag] <= bus.wb_data;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: it tracks expected retirements in a tag queue with a per-tag payload model,
// and it checks every commit in order as it appears.
module tb_reorder_buffer;
    localparam int DEPTH  = 8;
    localparam int TAG_W  = 3;
    localparam int REG_W  = 5;
    localparam int DATA_W = 64;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    reorder_buffer_if #(.TAG_W(TAG_W), .REG_W(REG_W), .DATA_W(DATA_W)) bus ();

    reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .REG_W(REG_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [TAG_W-1:0]  expTags [$];
    logic [REG_W-1:0]  mDest [DEPTH];
    logic              mWrEn [DEPTH];
    logic [DATA_W-1:0] mData [DEPTH];
    logic [TAG_W-1:0]  mTail;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic wr, input logic [REG_W-1:0] dest,
                                 input logic wbv, input logic [TAG_W-1:0] wbt,
                                 input logic [DATA_W-1:0] wbd, input logic fl);
        bus.alloc_valid = av;
        bus.alloc_wr_en = wr;
        bus.alloc_dest  = dest;
        bus.wb_valid    = wbv;
        bus.wb_tag      = wbt;
        bus.wb_data     = wbd;
        bus.flush       = fl;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic checkCommit();
        logic [TAG_W-1:0] t;
        if (bus.commit_valid === 1'b1) begin
            if (expTags.size() == 0) begin
                checkOutput("unexpected_commit", 64'(bus.commit_valid), 64'd0);
            end else begin
                t = expTags.pop_front();
                checkOutput("commit_tag",   64'(bus.commit_tag),   64'(t));
                checkOutput("commit_dest",  64'(bus.commit_dest),  64'(mDest[t]));
                checkOutput("commit_wr_en", 64'(bus.commit_wr_en), 64'(mWrEn[t]));
                checkOutput("commit_data",  bus.commit_data,       mData[t]);
            end
        end
    endtask

    // Starts just after a falling edge with inputs driven, and returns at the next falling edge.
    task automatic cycle();
        #1;
        checkCommit();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic allocate(input logic [REG_W-1:0] dest, input logic wr);
        applyStimulus(1'b1, wr, dest, 1'b0, '0, '0, 1'b0);
        #1;
        checkOutput("alloc_ready", 64'(bus.alloc_ready), 64'd1);
        checkOutput("alloc_tag",   64'(bus.alloc_tag),   64'(mTail));
        mDest[mTail] = dest;
        mWrEn[mTail] = wr;
        expTags.push_back(mTail);
        mTail++;
        cycle();
        idle();
    endtask

    task automatic writeback(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, tag, data, 1'b0);
        mData[tag] = data;
        cycle();
        idle();
    endtask

    task automatic clearModel();
        expTags.delete();
        mTail = '0;
    endtask

    initial begin
        reset = 1'b1;
        bus.rd_tag = '0;
        idle();
        clearModel();
        @(negedge clk);
        #1;
        checkOutput("reset_count",        64'(bus.count),        64'd0);
        checkOutput("reset_alloc_ready",  64'(bus.alloc_ready),  64'd1);
        checkOutput("reset_alloc_tag",    64'(bus.alloc_tag),    64'd0);
        checkOutput("reset_commit_valid", 64'(bus.commit_valid), 64'd0);
        checkOutput("reset_commit_data",  bus.commit_data,       64'd0);
        checkOutput("reset_rd_done",      64'(bus.rd_done),      64'd0);
        @(negedge clk);
        reset = 1'b0;

        // In-order allocation, then out-of-order writeback.
        allocate(5'd1, 1'b1);
        allocate(5'd2, 1'b1);
        allocate(5'd3, 1'b1);
        #1;
        checkOutput("t1_count",        64'(bus.count),        64'd3);
        checkOutput("t1_commit_valid", 64'(bus.commit_valid), 64'd0);
        writeback(3'd2, 64'hAA);
        #1;
        checkOutput("t2_cv_after_tag2", 64'(bus.commit_valid), 64'd0);
        writeback(3'd1, 64'hBB);
        #1;
        checkOutput("t2_cv_after_tag1", 64'(bus.commit_valid), 64'd0);
        writeback(3'd0, 64'hCC);
        #1;
        checkOutput("t2_cv_after_tag0", 64'(bus.commit_valid), 64'd1);
        cycle();
        #1;
        checkOutput("t2_cv_second", 64'(bus.commit_valid), 64'd1);
        cycle();
        #1;
        checkOutput("t2_cv_third", 64'(bus.commit_valid), 64'd1);
        cycle();
        #1;
        checkOutput("t2_count_drained", 64'(bus.count),        64'd0);
        checkOutput("t2_cv_drained",    64'(bus.commit_valid), 64'd0);
        @(negedge clk);

        // Fill from a clean state, test that a ninth request is refused, and test that the tail wraps to tag 0.
        reset = 1'b1;
        #1;
        reset = 1'b0;
        clearModel();
        for (int i = 0; i < DEPTH; i++) allocate(REG_W'(8 + i), 1'b1);
        #1;
        checkOutput("t3_full_ready", 64'(bus.alloc_ready), 64'd0);
        checkOutput("t3_full_count", 64'(bus.count),       64'd8);
        applyStimulus(1'b1, 1'b1, 5'd20, 1'b0, '0, '0, 1'b0);
        cycle();
        idle();
        #1;
        checkOutput("t3_ninth_count", 64'(bus.count),       64'd8);
        checkOutput("t3_ninth_ready", 64'(bus.alloc_ready), 64'd0);
        writeback(3'd0, 64'h1000);
        #1;
        checkOutput("t3_head_cv",    64'(bus.commit_valid), 64'd1);
        checkOutput("t3_head_ready", 64'(bus.alloc_ready),  64'd0);
        cycle();
        #1;
        checkOutput("t3_ready_after", 64'(bus.alloc_ready), 64'd1);
        checkOutput("t3_count_after", 64'(bus.count),       64'd7);
        allocate(5'd21, 1'b1);

        // Same-cycle bypass on the lookup port, then stored values.
        bus.rd_tag = 3'd3;
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 3'd3, 64'h55, 1'b0);
        mData[3] = 64'h55;
        #1;
        checkOutput("t4_bypass_done", 64'(bus.rd_done), 64'd1);
        checkOutput("t4_bypass_data", bus.rd_data,      64'h55);
        bus.rd_tag = 3'd4;
        #1;
        checkOutput("t4_pending_done", 64'(bus.rd_done), 64'd0);
        checkOutput("t4_pending_data", bus.rd_data,      64'd0);
        cycle();
        idle();
        bus.rd_tag = 3'd3;
        #1;
        checkOutput("t4_stored_done", 64'(bus.rd_done), 64'd1);
        checkOutput("t4_stored_data", bus.rd_data,      64'h55);

        // A flush squashes a ready head, and writebacks to old tags are then ignored.
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1);
        cycle();
        idle();
        clearModel();
        for (int i = 0; i < 5; i++) allocate(REG_W'(1 + i), 1'b1);
        writeback(3'd0, 64'h77);
        bus.flush = 1'b1;
        #1;
        checkOutput("t5_flush_cv", 64'(bus.commit_valid), 64'd0);
        cycle();
        idle();
        clearModel();
        #1;
        checkOutput("t5_count",     64'(bus.count),        64'd0);
        checkOutput("t5_alloc_tag", 64'(bus.alloc_tag),    64'd0);
        checkOutput("t5_cv",        64'(bus.commit_valid), 64'd0);
        bus.rd_tag = 3'd2;
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 3'd2, 64'h99, 1'b0);
        #1;
        checkOutput("t5_stale_bypass", 64'(bus.rd_done), 64'd0);
        cycle();
        idle();
        #1;
        checkOutput("t5_stale_done",  64'(bus.rd_done), 64'd0);
        checkOutput("t5_stale_count", 64'(bus.count),   64'd0);
        bus.rd_tag = 3'd5;
        #1;
        checkOutput("t5_free_done", 64'(bus.rd_done), 64'd0);
        checkOutput("t5_free_data", bus.rd_data,      64'd0);
        @(negedge clk);

        // Reset takes effect between clock edges.
        for (int i = 0; i < 4; i++) allocate(REG_W'(4 + i), 1'b1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t6_count",     64'(bus.count),        64'd0);
        checkOutput("t6_ready",     64'(bus.alloc_ready),  64'd1);
        checkOutput("t6_alloc_tag", 64'(bus.alloc_tag),    64'd0);
        checkOutput("t6_cv",        64'(bus.commit_valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        clearModel();

        // Non-writing instructions retire with commit_wr_en low.
        allocate(5'd9, 1'b0);
        allocate(5'd10, 1'b1);
        writeback(3'd1, 64'hB1);
        writeback(3'd0, 64'hB0);
        cycle();
        cycle();
        #1;
        checkOutput("t7_count", 64'(bus.count), 64'd0);
        checkOutput("scoreboard_drained", 64'(expTags.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement buffer for the out-of-order core. It sits downstream of dispatch and upstream of the architectural register file.
- Dispatch allocates one entry per cycle in program order. Execution units write results back out of order by tag.
- The head entry commits to the register file once its result has arrived.
- A flush input squashes every in-flight entry, for mispredicts and exceptions.

Parameters:
- DEPTH, 8, number of entries; must be a power of 2, minimum 2.
- TAG_W, 3, tag width; equals log2(DEPTH).
- REG_W, 5, architectural register index width.
- DATA_W, 64, result data width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  squash all entries at the next edge.
- alloc_valid  in  1  dispatch requests an entry.
- alloc_ready  out  1  buffer not full.
- alloc_wr_en  in  1  instruction writes a destination register.
- alloc_dest  in  REG_W  destination register index.
- alloc_tag  out  TAG_W  tag to be assigned (current tail pointer); combinational.
- wb_valid  in  1  execution result valid.
- wb_tag  in  TAG_W  entry the result belongs to.
- wb_data  in  DATA_W  result value.
- rd_tag  in  TAG_W  operand lookup tag.
- rd_done  out  1  entry at rd_tag holds a result.
- rd_data  out  DATA_W  result value for rd_tag.
- commit_valid  out  1  head entry retires this cycle.
- commit_wr_en  out  1  retiring entry writes a register.
- commit_dest  out  REG_W  retiring destination register.
- commit_data  out  DATA_W  retiring result value.
- commit_tag  out  TAG_W  retiring entry's tag (head pointer).
- count  out  TAG_W+1  number of occupied entries.

Behaviour:
- Per-entry state: valid, done, wr_en, dest, data.
- Head and tail pointers are TAG_W bits wide and wrap modulo DEPTH. count is 0..DEPTH.
- Reset (async): all valid/done bits cleared, head=tail=0, count=0. Consequently commit_valid=0, alloc_ready=1, rd_done=0, alloc_tag=0. Data fields need no reset; outputs must read 0 when their entry is invalid.
- Allocation:
  - Accepted when alloc_valid & alloc_ready & !flush.
  - At the edge: entry[tail] gets valid=1, done=0, wr_en, dest. tail advances by 1.
  - alloc_ready = (count != DEPTH). It does not anticipate a same-cycle commit, so when full, a commit and an alloc never coincide.
- Writeback:
  - At the edge, if wb_valid & entry[wb_tag].valid & !flush: done=1 and data=wb_data.
  - Writeback to an invalid entry is ignored.
  - A repeat writeback to a done entry overwrites the data.
- Commit:
  - commit_valid = entry[head].valid & entry[head].done & !flush; combinational.
  - When high, at the edge: entry[head] is cleared and head advances by 1.
  - No backpressure; at most one commit per cycle.
  - commit_wr_en/dest/data/tag reflect entry[head], gated to 0 when commit_valid=0.
  - Latency: a writeback at edge N to the head entry produces commit_valid=1 in the cycle after edge N and retires at edge N+1. Same-edge write-and-retire is not supported.
- Simultaneous alloc and commit: count unchanged, both pointers advance.
- Lookup port:
  - rd_done/rd_data are combinational.
  - If wb_valid & wb_tag==rd_tag & entry valid, returns wb_data with rd_done=1 (same-cycle bypass).
  - Otherwise returns the stored done/data.
  - Invalid entry: rd_done=0, rd_data=0.
- Flush:
  - At the edge: all entries invalidated, head=tail=0, count=0.
  - Overrides alloc, writeback and commit in the same cycle.
  - commit_valid is forced 0 while flush is high.
  - The cycle after flush behaves as post-reset.
- Empty (count=0): commit_valid=0, head==tail. Full (count=DEPTH): head==tail, alloc_ready=0. count is what disambiguates the two.
- Reset asserted mid-operation: immediate return to reset state regardless of the clock.

Test Plan:
1. Reset, then allocate 3 entries (dest 1,2,3, wr_en=1) -> alloc_tag 0,1,2; count=3; commit_valid=0.
2. Write back tag 2 (0xAA), then tag 1 (0xBB), then tag 0 (0xCC) -> commits occur in order, tags 0,1,2 with data 0xCC,0xBB,0xAA. The first commit_valid appears the cycle after tag 0's writeback edge. count reaches 0.
3. Allocate 8 entries -> alloc_ready=0, count=8. A 9th alloc_valid is ignored. Write back the head, commit it -> alloc_ready=1 the next cycle, and the next alloc gets tag 0 (wrap-around).
4. rd_tag=3 while wb_valid with wb_tag=3 and wb_data=0x55 -> rd_done=1, rd_data=0x55 in the same cycle. rd_tag on a free entry -> rd_done=0, rd_data=0.
5. 5 entries in flight, head done, flush=1 -> commit_valid=0 that cycle. Next cycle count=0, alloc_tag=0, and a writeback to an old tag is ignored.
6. Assert reset asynchronously mid-cycle with 4 entries valid -> count=0 and alloc_ready=1 immediately, before the next edge.
